// File: rtl/rv32_pkg.sv
// Shared types for the execute-stage multiply/divide unit: op encoding (RV funct3),
// FSM states and the divide iteration count helper.
package rv32_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } muldiv_op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_FIX,
    ST_DONE
  } muldiv_state_e;

  function automatic int MULDIV_DIV_CYCLES(input int xlen, input int div_bits);
    return xlen / div_bits;
  endfunction

endpackage

// File: rtl/muldiv_div_step.sv
// One combinational radix-2^DIV_BITS restoring divide step; dividend bits enter MSB first.
// Invariant: rem_i < dvsr_i, so every trial fits in XLEN+1 bits.
module muldiv_div_step #(
  parameter int XLEN     = 32,
  parameter int DIV_BITS = 1
) (
  input  logic [XLEN-1:0]     rem_i,
  input  logic [XLEN-1:0]     dvsr_i,
  input  logic [DIV_BITS-1:0] bits_i,
  output logic [XLEN-1:0]     rem_o,
  output logic [DIV_BITS-1:0] q_o
);

  logic [XLEN:0]   trial;
  logic [XLEN-1:0] r;

  always_comb begin
    r     = rem_i;
    q_o   = '0;
    trial = '0;
    for (int i = DIV_BITS - 1; i >= 0; i--) begin
      trial = {r, bits_i[i]};
      if (trial >= {1'b0, dvsr_i}) begin
        trial  = trial - {1'b0, dvsr_i};
        q_o[i] = 1'b1;
      end
      r = trial[XLEN-1:0];
    end
    rem_o = r;
  end

endmodule

// File: rtl/muldiv_unit.sv
// RV M-extension multiply/divide: MUL_LAT-cycle multiply, XLEN/DIV_BITS+2 cycle divide,
// 1-cycle special cases; one op in flight, response held until resp_ready_i.
module muldiv_unit
  import rv32_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int DIV_BITS = 1,
  parameter int MUL_LAT  = 1,
  parameter int TAG_W    = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [2:0]       req_op_i,
  input  logic [XLEN-1:0]  req_a_i,
  input  logic [XLEN-1:0]  req_b_i,
  input  logic [TAG_W-1:0] req_tag_i,
  output logic             resp_valid_o,
  input  logic             resp_ready_i,
  output logic [XLEN-1:0]  resp_data_o,
  output logic [TAG_W-1:0] resp_tag_o,
  output logic             busy_o
);

  localparam int DIV_CYC = MULDIV_DIV_CYCLES(XLEN, DIV_BITS);
  localparam int MUL_CNT = (MUL_LAT > 1) ? MUL_LAT - 2 : 0;

  muldiv_state_e   state, state_n;
  muldiv_op_e      op;
  logic            accept;
  logic [31:0]     cnt;
  logic [XLEN-1:0] rem_q, quo_q, dvsr_q;
  logic            neg_q, neg_r, is_rem;
  logic [TAG_W-1:0] tag_q;

  assign op          = muldiv_op_e'(req_op_i);
  assign req_ready_o = !flush_i && (state == ST_IDLE || (state == ST_DONE && resp_ready_i));
  assign accept      = req_valid_i && req_ready_o;
  assign busy_o      = (state != ST_IDLE);
  assign resp_tag_o  = tag_q;

  // Sign-extend to 2*XLEN so one unsigned multiplier covers all four products.
  logic             a_sgn, b_sgn;
  logic [2*XLEN-1:0] a_ext, b_ext, prod;
  logic [XLEN-1:0]  mul_res;
  assign a_sgn   = (op == OP_MULH) || (op == OP_MULHSU);
  assign b_sgn   = (op == OP_MULH);
  assign a_ext   = {{XLEN{a_sgn & req_a_i[XLEN-1]}}, req_a_i};
  assign b_ext   = {{XLEN{b_sgn & req_b_i[XLEN-1]}}, req_b_i};
  assign prod    = a_ext * b_ext;
  assign mul_res = (op == OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];

  logic            is_div, div_sgn, a_neg, b_neg, b_zero, ovf, special;
  logic [XLEN-1:0] abs_a, abs_b, special_res, fix_res, step_rem;
  logic [DIV_BITS-1:0] step_q;
  assign is_div  = req_op_i[2];
  assign div_sgn = (op == OP_DIV) || (op == OP_REM);
  assign a_neg   = div_sgn & req_a_i[XLEN-1];
  assign b_neg   = div_sgn & req_b_i[XLEN-1];
  assign abs_a   = a_neg ? -req_a_i : req_a_i;
  assign abs_b   = b_neg ? -req_b_i : req_b_i;
  assign b_zero  = (req_b_i == '0);
  assign ovf     = div_sgn && (req_a_i == {1'b1, {(XLEN-1){1'b0}}}) && (&req_b_i);
  assign special = b_zero || ovf;
  // req_op_i[1] selects remainder (REM/REMU) over quotient (DIV/DIVU).
  assign special_res = b_zero ? (req_op_i[1] ? req_a_i : {XLEN{1'b1}})
                              : (req_op_i[1] ? {XLEN{1'b0}} : req_a_i);
  assign fix_res = is_rem ? (neg_r ? -rem_q : rem_q) : (neg_q ? -quo_q : quo_q);

  muldiv_div_step #(.XLEN(XLEN), .DIV_BITS(DIV_BITS)) u_step (
    .rem_i  (rem_q),
    .dvsr_i (dvsr_q),
    .bits_i (quo_q[XLEN-1 -: DIV_BITS]),
    .rem_o  (step_rem),
    .q_o    (step_q)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (flush_i) begin
      state_n = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (state == ST_DONE && resp_ready_i) state_n = ST_IDLE;
          if (accept) begin
            if (!is_div) begin
              if (MUL_LAT > 1) state_n = ST_MUL;
              else             state_n = ST_DONE;
            end else if (special) begin
              state_n = ST_DONE;
            end else begin
              state_n = ST_DIV;
            end
          end
        end
        ST_MUL:  if (cnt == 0) state_n = ST_DONE;
        ST_DIV:  if (cnt == 0) state_n = ST_FIX;
        ST_FIX:  state_n = ST_DONE;
        default: state_n = ST_IDLE;
      endcase
    end
  end

  // quo_q doubles as the multiply retiming register while in ST_MUL.
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid_o <= 1'b0;
      resp_data_o  <= '0;
      tag_q        <= '0;
      cnt          <= '0;
      rem_q        <= '0;
      quo_q        <= '0;
      dvsr_q       <= '0;
      neg_q        <= 1'b0;
      neg_r        <= 1'b0;
      is_rem       <= 1'b0;
    end else if (flush_i) begin
      resp_valid_o <= 1'b0;
    end else begin
      if (state == ST_DONE && resp_ready_i) resp_valid_o <= 1'b0;
      case (state)
        ST_MUL: begin
          if (cnt == 0) begin
            resp_data_o  <= quo_q;
            resp_valid_o <= 1'b1;
          end else begin
            cnt <= cnt - 1;
          end
        end
        ST_DIV: begin
          rem_q <= step_rem;
          quo_q <= {quo_q[XLEN-DIV_BITS-1:0], step_q};
          cnt   <= cnt - 1;
        end
        ST_FIX: begin
          resp_data_o  <= fix_res;
          resp_valid_o <= 1'b1;
        end
        default: ;
      endcase
      if (accept) begin
        tag_q <= req_tag_i;
        if (!is_div) begin
          if (MUL_LAT == 1) begin
            resp_data_o  <= mul_res;
            resp_valid_o <= 1'b1;
          end else begin
            quo_q <= mul_res;
            cnt   <= 32'(MUL_CNT);
          end
        end else if (special) begin
          resp_data_o  <= special_res;
          resp_valid_o <= 1'b1;
        end else begin
          rem_q  <= '0;
          quo_q  <= abs_a;
          dvsr_q <= abs_b;
          neg_q  <= a_neg ^ b_neg;
          neg_r  <= a_neg;
          is_rem <= req_op_i[1];
          cnt    <= 32'(DIV_CYC - 1);
        end
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench: radix-2/MUL_LAT=1 unit plus a radix-16/MUL_LAT=3 unit sharing request data.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, flush, resp_ready, resp_ready4, req_valid, req_valid4;
  logic [2:0]  req_op;
  logic [31:0] req_a, req_b;
  logic [4:0]  req_tag;

  logic        req_ready, resp_valid, busy;
  logic [31:0] resp_data;
  logic [4:0]  resp_tag;
  logic        req_ready4, resp_valid4, busy4;
  logic [31:0] resp_data4;
  logic [4:0]  resp_tag4;

  muldiv_unit #(.XLEN(32), .DIV_BITS(1), .MUL_LAT(1), .TAG_W(5)) dut (
    .clk(clk), .rst(rst), .flush_i(flush),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_op_i(req_op),
    .req_a_i(req_a), .req_b_i(req_b), .req_tag_i(req_tag),
    .resp_valid_o(resp_valid), .resp_ready_i(resp_ready),
    .resp_data_o(resp_data), .resp_tag_o(resp_tag), .busy_o(busy)
  );

  muldiv_unit #(.XLEN(32), .DIV_BITS(4), .MUL_LAT(3), .TAG_W(5)) dut4 (
    .clk(clk), .rst(rst), .flush_i(flush),
    .req_valid_i(req_valid4), .req_ready_o(req_ready4), .req_op_i(req_op),
    .req_a_i(req_a), .req_b_i(req_b), .req_tag_i(req_tag),
    .resp_valid_o(resp_valid4), .resp_ready_i(resp_ready4),
    .resp_data_o(resp_data4), .resp_tag_o(resp_tag4), .busy_o(busy4)
  );

  logic        sel4;
  logic        m_rdy, m_vld, m_busy;
  logic [31:0] m_dat;
  logic [4:0]  m_tag;
  assign m_rdy  = sel4 ? req_ready4  : req_ready;
  assign m_vld  = sel4 ? resp_valid4 : resp_valid;
  assign m_busy = sel4 ? busy4       : busy;
  assign m_dat  = sel4 ? resp_data4  : resp_data;
  assign m_tag  = sel4 ? resp_tag4   : resp_tag;

  int checks = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", name, got, exp);
  endtask

  // Issue one op at a negedge, measure accept-to-valid latency, check result, let it drain.
  task automatic run(input logic s4, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [4:0] tag, input int lat_exp, input logic [31:0] exp, input string name);
    int lat;
    sel4 = s4;
    req_op = op; req_a = a; req_b = b; req_tag = tag;
    #1;
    chk({name, " req_ready"}, 32'(m_rdy), 32'd1);
    if (s4) req_valid4 = 1'b1;
    else    req_valid  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; req_valid4 = 1'b0;
    lat = 1;
    while (!m_vld && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    chk({name, " latency"}, 32'(lat), 32'(lat_exp));
    chk({name, " data"}, m_dat, exp);
    chk({name, " tag"}, 32'(m_tag), 32'(tag));
    @(negedge clk);
    chk({name, " busy after"}, 32'(m_busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit seen;
    rst = 1'b1; flush = 1'b0; resp_ready = 1'b1; resp_ready4 = 1'b1;
    req_valid = 1'b0; req_valid4 = 1'b0; req_op = 3'd0; req_a = '0; req_b = '0; req_tag = '0;
    sel4 = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("reset req_ready", 32'(req_ready), 32'd1);
    chk("reset resp_valid", 32'(resp_valid), 32'd0);
    chk("reset resp_data", resp_data, 32'd0);
    chk("reset resp_tag", 32'(resp_tag), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run(0, 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd1, 1, 32'h00000000, "mulh");
    run(0, 3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2, 1, 32'hFFFFFFFE, "mulhu");
    run(0, 3'd2, 32'hFFFFFFFF, 32'd2,        5'd3, 1, 32'hFFFFFFFF, "mulhsu");
    run(0, 3'd0, 32'd7,        32'hFFFFFFFD, 5'd4, 1, 32'hFFFFFFEB, "mul");
    run(0, 3'd4, 32'hFFFFFFF9, 32'd2,        5'd5, 34, 32'hFFFFFFFD, "div");
    run(0, 3'd6, 32'hFFFFFFF9, 32'd2,        5'd6, 34, 32'hFFFFFFFF, "rem");
    run(0, 3'd5, 32'd5,        32'd0,        5'd7, 1, 32'hFFFFFFFF, "divu by0");
    run(0, 3'd6, 32'd5,        32'd0,        5'd8, 1, 32'd5,        "rem by0");
    run(0, 3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd9, 1, 32'h80000000, "div ovf");
    run(0, 3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd10, 1, 32'd0,       "rem ovf");
    run(0, 3'd7, 32'd100,      32'd7,        5'd12, 34, 32'd2,       "remu");

    run(1, 3'd4, 32'hFFFFFFF9, 32'd2,        5'd13, 10, 32'hFFFFFFFD, "div r16");
    run(1, 3'd6, 32'hFFFFFFF9, 32'd2,        5'd14, 10, 32'hFFFFFFFF, "rem r16");
    run(1, 3'd0, 32'd7,        32'hFFFFFFFD, 5'd15, 3,  32'hFFFFFFEB, "mul lat3");
    run(1, 3'd5, 32'd1000,     32'd7,        5'd16, 10, 32'd142,      "divu r16");
    sel4 = 1'b0;

    // Backpressure: hold the response five cycles, then accept a new op in the release cycle.
    resp_ready = 1'b0;
    req_op = 3'd0; req_a = 32'd3; req_b = 32'd4; req_tag = 5'd20; req_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("bp valid", 32'(resp_valid), 32'd1);
      chk("bp data", resp_data, 32'd12);
      chk("bp tag", 32'(resp_tag), 32'd20);
      chk("bp req_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
    end
    resp_ready = 1'b1;
    req_op = 3'd3; req_a = 32'h00010000; req_b = 32'h00010000; req_tag = 5'd21; req_valid = 1'b1;
    #1;
    chk("b2b req_ready", 32'(req_ready), 32'd1);
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0;
    chk("b2b valid", 32'(resp_valid), 32'd1);
    chk("b2b data", resp_data, 32'd1);
    chk("b2b tag", 32'(resp_tag), 32'd21);
    chk("b2b busy", 32'(busy), 32'd1);
    @(negedge clk);
    chk("b2b drained valid", 32'(resp_valid), 32'd0);
    chk("b2b drained busy", 32'(busy), 32'd0);

    // Flush during divide iteration 10.
    req_op = 3'd4; req_a = 32'd1000; req_b = 32'd3; req_tag = 5'd22; req_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush busy", 32'(busy), 32'd0);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (resp_valid) seen = 1'b1;
    end
    chk("flush no response", 32'(seen), 32'd0);

    // A request presented during a flush in IDLE must not be taken.
    flush = 1'b1;
    req_op = 3'd0; req_a = 32'd2; req_b = 32'd2; req_tag = 5'd23; req_valid = 1'b1;
    #1;
    chk("flush req_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    flush = 1'b0; req_valid = 1'b0;
    chk("flush no accept valid", 32'(resp_valid), 32'd0);
    chk("flush no accept busy", 32'(busy), 32'd0);

    run(0, 3'd5, 32'd100, 32'd7, 5'd11, 34, 32'd14, "divu after flush");

    // Reset mid-divide.
    req_op = 3'd4; req_a = 32'd100; req_b = 32'd7; req_tag = 5'd24; req_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst valid", 32'(resp_valid), 32'd0);
    chk("rst data", resp_data, 32'd0);
    chk("rst tag", 32'(resp_tag), 32'd0);
    run(0, 3'd0, 32'd3, 32'd4, 5'd25, 1, 32'd12, "mul after rst");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Parametrised, handshaked multi-cycle integer multiply/divide unit implementing the full RV M-extension (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU). It sits beside the single-cycle ALU in the execute stage. Execute hands it an operation under a valid/ready handshake, holds dependent instructions while `busy_o` is high, and retires the result with its destination tag. Divide width per cycle and multiply latency are configurable, and an in-flight operation can be killed by a pipeline flush.

## Interface
- `XLEN`, 32: operand/result width; even, ≥ 8.
- `DIV_BITS`, 1: quotient bits retired per divide iteration; must divide `XLEN` and be one of 1, 2, 4.
- `MUL_LAT`, 1: cycles from accept to multiply result valid; ≥ 1.
- `TAG_W`, 5: width of the opaque tag carried with each operation (rd index).

- `clk` in 1: sole clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `flush_i` in 1: kills any in-flight or pending operation.
- `req_valid_i` in 1: request present.
- `req_ready_o` out 1: unit can accept.
- `req_op_i` in 3: `muldiv_op_e`, encoded as RV funct3 (0 MUL … 7 REMU).
- `req_a_i` in XLEN: rs1.
- `req_b_i` in XLEN: rs2.
- `req_tag_i` in TAG_W: tag.
- `resp_valid_o` out 1: result present.
- `resp_ready_i` in 1: consumer takes result.
- `resp_data_o` out XLEN: result.
- `resp_tag_o` out TAG_W: tag of the result.
- `busy_o` out 1: state ≠ IDLE; execute stalls on it.

## Operation
- FSM states:
  - IDLE
  - MUL: counts `MUL_LAT`−1 cycles.
  - DIV: iterations.
  - FIX: sign correction.
  - DONE: holds the response.
- Accept happens when `req_valid_i && req_ready_o`. Operands, op and tag are registered on that edge; inputs are ignored afterward.
- `req_ready_o` = !`flush_i` && (IDLE || (DONE && `resp_ready_i`)), which allows back-to-back accept in the same cycle a response is consumed.
- Multiply:
  - Form a 2·XLEN product with operands extended per op: MULH both signed, MULHSU a signed / b unsigned, MULHU both unsigned.
  - MUL returns low XLEN bits; the other three return high XLEN bits.
- Divide uses magnitudes: |a|, |b| for DIV/REM; raw values for DIVU/REMU.
  - Iterative restoring divide retires `DIV_BITS` quotient bits per cycle over XLEN/DIV_BITS cycles.
  - FIX negates the quotient if a[XLEN-1]^b[XLEN-1] (DIV), and negates the remainder if a[XLEN-1] (REM).
- Special cases bypass DIV/FIX and go straight to DONE. They are resolved at accept:
  - b=0: DIV/DIVU → all ones; REM/REMU → a.
  - DIV with a = 1<<(XLEN-1) and b = all ones → a. The matching REM → 0.
- `flush_i`:
  - Next state IDLE and `resp_valid_o` low next cycle.
  - A response in DONE is dropped.
  - No accept occurs in a flush cycle.
- `rst`: all outputs 0 next edge, state IDLE. Dominates `flush_i` and any handshake.

## Timing
- Reset values: `req_ready_o`=1 (if `flush_i`=0), `resp_valid_o`=0, `resp_data_o`=0, `resp_tag_o`=0, `busy_o`=0.
- Latency counts from the accept edge to the first cycle `resp_valid_o`=1:
  - mul ops: `MUL_LAT`.
  - div/rem ops: XLEN/DIV_BITS + 2 (XLEN=32, DIV_BITS=1 → 34).
  - special cases: 1.
- `resp_valid_o`, `resp_data_o` and `resp_tag_o` are registered. They stay stable while `resp_valid_o && !resp_ready_i`.
- All responses return in accept order; there is never more than one operation in flight.
- `busy_o` goes high the cycle after accept and stays high through DONE. It is low in the cycle after consumption unless a new op was accepted back-to-back.

## Structure
- `rv32_pkg` gains:
  - `muldiv_op_e` (MUL=0, MULH=1, MULHSU=2, MULHU=3, DIV=4, DIVU=5, REM=6, REMU=7).
  - `muldiv_state_e`.
  - Helper constant `MULDIV_DIV_CYCLES(XLEN, DIV_BITS)`.
- One sub-module, `muldiv_div_step`: combinational radix-2^DIV_BITS restoring step (partial remainder, divisor, dividend bits in → next partial remainder, quotient bits out). It is instantiated once inside `muldiv_unit`.
- The multiplier stays inline. `MUL_LAT`>1 adds retiming registers after the product for synthesis.

## Test plan
All cases XLEN=32 unless noted.
- MULH a=0xFFFFFFFF, b=0xFFFFFFFF → 0x00000000 after 1 cycle; MULHU with the same operands → 0xFFFFFFFE; MULHSU a=0xFFFFFFFF, b=2 → 0xFFFFFFFF; MUL 7·(−3) → 0xFFFFFFEB.
- DIV −7/2 → 0xFFFFFFFD and REM −7/2 → 0xFFFFFFFF, each after 34 cycles; repeat with DIV_BITS=4 → 10 cycles.
- DIVU 5/0 → 0xFFFFFFFF, REM 5/0 → 5, DIV 0x80000000/0xFFFFFFFF → 0x80000000, REM of the same → 0; each valid 1 cycle after accept.
- Backpressure: hold `resp_ready_i`=0 for 5 cycles after valid → data/tag stable and `req_ready_o`=0; then present a new op in the release cycle → accepted back-to-back.
- Assert `flush_i` at DIV iteration 10 → `resp_valid_o` never rises for that tag; the next DIVU 100/7 → 14 with its own tag.
- Assert `rst` mid-DIV → next cycle `busy_o`=0, `resp_valid_o`=0, `resp_data_o`=0, and a fresh MUL 3·4 returns 12.
